// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// Define BCD_CHECK_EN to flag operands with a nibble above 9 (bcd_err, data_bin forced to 0).
module bcd_to_bin #(
  parameter int SHIFT_CNT_MAX = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] data_bcd,
  output logic        busy,
  output logic        done,
  output logic [13:0] data_bin,
  output logic        bcd_err
);

  localparam int CNT_W = $clog2(SHIFT_CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [29:0]      work;

  // A BCD nibble >= 8 after a right shift held a carried-in half-ten; remove the excess 3.
  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  function automatic logic [29:0] adjust_work(input logic [29:0] w);
    logic [29:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      r[14 + 4*i +: 4] = nib_adj(w[14 + 4*i +: 4]);
    end
    return r;
  endfunction

`ifdef BCD_CHECK_EN
  logic err_lat;

  function automatic logic bad_digit(input logic [15:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // The counter value after this shift decides whether another adjust/shift pair follows.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt_inc < CNT_W'(SHIFT_CNT_MAX)) ? ADJUST : DONE;
      ADJUST:  state_nxt = SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      work     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_bin <= '0;
`ifdef BCD_CHECK_EN
      err_lat  <= 1'b0;
      bcd_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work    <= {data_bcd, 14'd0};
            busy    <= 1'b1;
            cnt     <= '0;
`ifdef BCD_CHECK_EN
            err_lat <= bad_digit(data_bcd);
`endif
          end
        end
        SHIFT: begin
          work <= {1'b0, work[29:1]};
          cnt  <= cnt_inc;
        end
        ADJUST: work <= adjust_work(work);
        DONE: begin
`ifdef BCD_CHECK_EN
          data_bin <= err_lat ? 14'd0 : work[13:0];
          bcd_err  <= err_lat;
`else
          data_bin <= work[13:0];
`endif
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_CHECK_EN
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin: latency, values, back-to-back starts,
// mid-conversion reset and the invalid-digit path (both BCD_CHECK_EN builds).
module tb_bcd_to_bin;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] data_bcd;
  logic        busy;
  logic        done;
  logic [13:0] data_bin;
  logic        bcd_err;

  int n_checks = 0;
  int n_err    = 0;

  bcd_to_bin #(.SHIFT_CNT_MAX(14)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .data_bcd  (data_bcd),
    .busy      (busy),
    .done      (done),
    .data_bin  (data_bin),
    .bcd_err   (bcd_err)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    b[15:12] = 4'((v / 1000) % 10);
    b[11:8]  = 4'((v / 100) % 10);
    b[7:4]   = 4'((v / 10) % 10);
    b[3:0]   = 4'(v % 10);
    return b;
  endfunction

  // Call right after the accepting edge E0; scrambles data_bcd to prove it is not re-sampled.
  task automatic wait_done(input int exp_bin, input int exp_err, input bit chk_bin, input string tag);
    int k;
    int busy_cyc;
    k = -1;
    busy_cyc = 0;
    do begin
      @(negedge sys_clk);
      k++;
      if (k == 0) begin
        start    = 1'b0;
        data_bcd = ~data_bcd;
      end
      if (!done && busy) busy_cyc++;
    end while (!done && k < 40);
    chk({tag, "_latency"}, k, 28);
    chk({tag, "_busy_cycles"}, busy_cyc, 28);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    if (chk_bin) chk({tag, "_bin"}, int'(data_bin), exp_bin);
    chk({tag, "_err"}, int'(bcd_err), exp_err);
    @(negedge sys_clk);
    chk({tag, "_done_width"}, int'(done), 0);
    chk({tag, "_bin_hold"}, int'(data_bin), chk_bin ? exp_bin : int'(data_bin));
  endtask

  task automatic do_conv(input logic [15:0] d, input int exp_bin, input int exp_err,
                         input bit chk_bin, input string tag);
    @(negedge sys_clk);
    start    = 1'b1;
    data_bcd = d;
    @(posedge sys_clk);
    wait_done(exp_bin, exp_err, chk_bin, tag);
  endtask

  initial begin
    int ndone;
    int v;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    data_bcd  = 16'h0000;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(data_bin), 0);
    chk("rst_err", int'(bcd_err), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("idle_busy", int'(busy), 0);

    do_conv(16'h9999, 9999, 0, 1'b1, "c9999");
    do_conv(16'h0000, 0,    0, 1'b1, "c0000");
    do_conv(16'h1234, 1234, 0, 1'b1, "c1234");
    do_conv(16'h0001, 1,    0, 1'b1, "c0001");

    // start held high: accepted at E0, E29, E58 only
    @(negedge sys_clk);
    start    = 1'b1;
    data_bcd = 16'h0042;
    @(posedge sys_clk);
    ndone = 0;
    for (int k = 0; k <= 90; k++) begin
      @(negedge sys_clk);
      if (done) begin
        chk("b2b_bin", int'(data_bin), 42);
        chk("b2b_when", k, 28 + 29 * ndone);
        ndone++;
      end
      if (k == 86) start = 1'b0;
    end
    chk("b2b_count", ndone, 3);

    // reset asserted at cycle 10 of a conversion
    @(negedge sys_clk);
    start    = 1'b1;
    data_bcd = 16'h0777;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (9) @(negedge sys_clk);
    chk("mid_busy_before", int'(busy), 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_bin", int'(data_bin), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    start     = 1'b1;
    data_bcd  = 16'h0502;
    @(posedge sys_clk);
    wait_done(502, 0, 1'b1, "post_rst");

`ifdef BCD_CHECK_EN
    do_conv(16'h00A5, 0, 1, 1'b1, "bad_a5");
`else
    do_conv(16'h00A5, 0, 0, 1'b0, "bad_a5");
`endif
    do_conv(16'h5090, 5090, 0, 1'b1, "after_bad");

    for (int i = 0; i < 24; i++) begin
      v = (i * 4217 + 13) % 10000;
      do_conv(to_bcd(v), v, 0, 1'b1, "regr");
    end
    do_conv(16'h8888, 8888, 0, 1'b1, "c8888");
    do_conv(16'h9990, 9990, 0, 1'b1, "c9990");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have parameter SHIFT_CNT_MAX, default 14, giving the shift iterations per conversion; 14 is the only supported value.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: system clock, 50 MHz, rising-edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge.
REQ-005 The block SHALL have port data_bcd, input, 16 bits: 4-digit 8421 BCD operand, digit 3 at [15:12] through digit 0 at [3:0].
REQ-006 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle completion strobe.
REQ-008 The block SHALL have port data_bin, output, 14 bits: unsigned binary result, range 0..9999.
REQ-009 The block SHALL have port bcd_err, output, 1 bit: invalid-digit flag, qualified by done.

Function
REQ-010 The algorithm SHALL be reverse double-dabble on a 30-bit work register {bcd[15:0], bin[13:0]}.
REQ-011 The FSM SHALL have 4 states: IDLE, SHIFT, ADJUST, DONE.
REQ-012 In IDLE with start=1 (edge E0), the block SHALL load work={data_bcd, 14'd0}, set busy=1, clear the shift counter, and go to SHIFT.
REQ-013 In IDLE with start=0, the block SHALL hold all registers.
REQ-014 In SHIFT, the block SHALL logically shift the work register right 1 bit with 0 into bit 29 and increment the counter.
REQ-015 From SHIFT, the FSM SHALL go to ADJUST if the counter is below SHIFT_CNT_MAX, otherwise to DONE.
REQ-016 In ADJUST, each of the 4 BCD nibbles of work SHALL have 3 subtracted when the nibble is >= 8, else hold (4-bit, no borrow across nibbles); the FSM then returns to SHIFT.
REQ-017 Edges E1..E27 SHALL carry 14 SHIFT cycles and 13 ADJUST cycles; the FSM SHALL be in DONE after E27.
REQ-018 In DONE (edge E28), the block SHALL register data_bin <= work[13:0], set done=1 and busy=0, and return to IDLE.
REQ-019 done SHALL be high exactly one cycle, the cycle after E28.
REQ-020 Latency SHALL be 28 clocks from start sample to done.
REQ-021 data_bin and bcd_err SHALL hold their values until the next DONE.
REQ-022 start SHALL be ignored while busy=1 or in DONE, with no queuing.
REQ-023 The earliest next accepted start SHALL be edge E29, giving a 29-cycle back-to-back period.
REQ-024 data_bcd SHALL be sampled only at E0; later changes SHALL not affect the result.

Reset
REQ-025 Asserting sys_rst_n=0 SHALL asynchronously force state=IDLE, counter=0, work=0, busy=0, done=0, data_bin=0, and bcd_err=0.
REQ-026 Reset asserted mid-conversion SHALL abort it with no done pulse; after release, the block SHALL be IDLE and accept start on the first edge.

Configuration
REQ-027 Macro BCD_CHECK_EN SHALL enable invalid-digit checking.
REQ-028 With BCD_CHECK_EN defined, at E0 the block SHALL latch an error bit if any data_bcd nibble is > 9.
REQ-029 With BCD_CHECK_EN defined, at DONE bcd_err SHALL take the latched bit and data_bin SHALL be forced to 0 when it is set; timing SHALL be unchanged.
REQ-030 With BCD_CHECK_EN undefined, no check logic SHALL exist, bcd_err SHALL be tied 0, and data_bin SHALL be the raw algorithm output for any input.

Verification
REQ-031 start pulse with data_bcd=16'h9999 -> done exactly 28 clocks later, data_bin=14'd9999 (0x270F), busy high for 28 cycles.
REQ-032 data_bcd=16'h0000, then 16'h1234, then 16'h0001 -> data_bin=0, then 1234, then 1; each done is 1 cycle wide.
REQ-033 start held high continuously -> conversions accepted at E0, E29, E58; start during busy produces no extra done.
REQ-034 sys_rst_n pulsed low at cycle 10 of a conversion -> busy=0 and done=0 immediately, data_bin=0, no done pulse; the next start converts correctly.
REQ-035 data_bcd=16'h00A5 with BCD_CHECK_EN defined -> bcd_err=1 and data_bin=0 at done.
REQ-036 data_bcd=16'h00A5 with BCD_CHECK_EN undefined -> bcd_err=0.
REQ-037 Valid-input regression -> bcd_err=0 for all 10000 valid inputs, with data_bin matching the decimal value.
